// File: rtl/usb3_ep0_tx_pkg.sv
// Shared EP0 control-IN transmit definitions: FSM encodings, default packet size
// and the last-word byte-enable decode.
package usb3_ep0_tx_pkg;

    localparam int EP0_MAX_PKT = 512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HDR,
        S_DATA,
        S_ARM,
        S_ARM_REL
    } ep0_tx_state_e;

    // Byte 0 sits in [31:24], so a short last word keeps its upper lanes.
    function automatic logic [3:0] last_be(input logic [1:0] rem);
        case (rem)
            2'd1:    return 4'b1000;
            2'd2:    return 4'b1100;
            2'd3:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/usb3_ep0_tx_if.sv
// EP0 buffer side and protocol-layer DP side of the EP0 transmitter.
// master = the transmitter, slave = endpoint/protocol layer around it.
interface usb3_ep0_tx_if;
    logic        ep_hasdata;
    logic [10:0] ep_len;
    logic [8:0]  ep_rd_addr;
    logic [31:0] ep_rd_q;
    logic        ep_arm;
    logic        ep_arm_ack;
    logic        tx_req;
    logic        tx_abort;
    logic        tx_start;
    logic [10:0] tx_len;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_be;
    logic        tx_last;
    logic        busy;
    logic        err_arm;

    modport master (
        input  ep_hasdata, ep_len, ep_rd_q, ep_arm_ack, tx_req, tx_abort, tx_ready,
        output ep_rd_addr, ep_arm, tx_start, tx_len, tx_data, tx_valid, tx_be, tx_last,
               busy, err_arm
    );

    modport slave (
        output ep_hasdata, ep_len, ep_rd_q, ep_arm_ack, tx_req, tx_abort, tx_ready,
        input  ep_rd_addr, ep_arm, tx_start, tx_len, tx_data, tx_valid, tx_be, tx_last,
               busy, err_arm
    );

endinterface

// File: rtl/usb3_ep0_tx_fifo.sv
// 4-entry sync FIFO holding prefetched EP0 buffer words; flush drops everything.
module usb3_ep0_tx_fifo #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic [2:0]   count_o
);
    logic [W-1:0] mem_q [4];
    logic [1:0]   wr_q, rd_q;
    logic [2:0]   cnt_q;
    logic         do_pop;

    assign do_pop  = pop_i && (cnt_q != 3'd0);
    assign empty_o = (cnt_q == 3'd0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 2'd1;
            end
            if (do_pop) rd_q <= rd_q + 2'd1;
            cnt_q <= cnt_q + {2'd0, push_i} - {2'd0, do_pop};
        end
    end

endmodule

// File: rtl/usb3_ep0_tx.sv
// EP0 control-IN transmitter: splits a buffered response into DPs of at most
// MAX_PKT bytes, prefetching buffer words under a 4-word credit, then arms EP0.
module usb3_ep0_tx
    import usb3_ep0_tx_pkg::*;
#(
    parameter int MAX_PKT     = EP0_MAX_PKT,
    parameter int RD_LAT      = 2,
    parameter int ARM_TIMEOUT = 255
) (
    input  logic          local_clk,
    input  logic          reset_n,
    usb3_ep0_tx_if.master bus
);
    localparam int TW = $clog2(ARM_TIMEOUT + 1);

    ep0_tx_state_e     state_q, state_d;
    logic [10:0]       remain_q, remain_d;
    logic [10:0]       pkt_q, pkt_d;
    logic [8:0]        rd_addr_q, rd_addr_d;
    logic [8:0]        issued_q, issued_d;
    logic [8:0]        popped_q, popped_d;
    logic [2:0]        inflight_q, inflight_d;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic [TW-1:0]     arm_cnt_q, arm_cnt_d;
    logic              err_q, err_d;

    logic [8:0]  nwords;
    logic        issue, push, pop, is_last;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic [2:0]  fifo_cnt;

    assign nwords  = 9'(pkt_q >> 2) + {8'd0, |pkt_q[1:0]};
    assign push    = rd_pipe_q[RD_LAT-1];
    assign pop     = !fifo_empty && bus.tx_ready;
    assign is_last = (popped_q == nwords - 9'd1);
    // In-flight reads plus buffered words never exceed the FIFO depth; a pop
    // this cycle already frees its slot.
    assign issue   = (state_q == S_DATA) && !bus.tx_abort && (issued_q < nwords) &&
                     (({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (4'd4 + {3'd0, pop}));

    usb3_ep0_tx_fifo #(.W(32)) u_fifo (
        .clk_i   (local_clk),
        .rst_ni  (reset_n),
        .flush_i (bus.tx_abort),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.ep_rd_q),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            remain_q   <= '0;
            pkt_q      <= '0;
            rd_addr_q  <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= '0;
            rd_pipe_q  <= '0;
            arm_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            pkt_q      <= pkt_d;
            rd_addr_q  <= rd_addr_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            inflight_q <= inflight_d;
            rd_pipe_q  <= bus.tx_abort ? '0 : RD_LAT'({rd_pipe_q, issue});
            arm_cnt_q  <= arm_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        pkt_d      = pkt_q;
        rd_addr_d  = issue ? rd_addr_q + 9'd1 : rd_addr_q;
        issued_d   = issued_q + {8'd0, issue};
        popped_d   = popped_q + {8'd0, pop};
        inflight_d = inflight_q + {2'd0, issue} - {2'd0, push};
        arm_cnt_d  = '0;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: if (bus.ep_hasdata) begin
                state_d   = S_WAIT;
                remain_d  = bus.ep_len;
                rd_addr_d = '0;
            end
            S_WAIT: if (bus.tx_req) begin
                state_d  = S_HDR;
                pkt_d    = (remain_q > 11'(MAX_PKT)) ? 11'(MAX_PKT) : remain_q;
                issued_d = '0;
                popped_d = '0;
            end
            S_HDR: state_d = (pkt_q == '0) ? S_ARM : S_DATA;
            S_DATA: if (pop && is_last) begin
                remain_d = remain_q - pkt_q;
                state_d  = (remain_q == pkt_q) ? S_ARM : S_WAIT;
            end
            S_ARM: begin
                arm_cnt_d = arm_cnt_q + TW'(1);
                if (bus.ep_arm_ack) begin
                    state_d = S_ARM_REL;
                end else if (arm_cnt_q == TW'(ARM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_ARM_REL;
                end
            end
            // Holding here until the endpoint drops hasdata avoids resending a stale response.
            S_ARM_REL: if (!bus.ep_hasdata) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.tx_abort) begin
            state_d    = S_IDLE;
            remain_d   = '0;
            inflight_d = '0;
        end
    end

    assign bus.ep_rd_addr = rd_addr_q;
    assign bus.ep_arm     = (state_q == S_ARM);
    assign bus.tx_start   = (state_q == S_HDR);
    assign bus.tx_len     = (state_q == S_HDR) ? pkt_q : '0;
    assign bus.tx_valid   = !fifo_empty;
    assign bus.tx_data    = fifo_empty ? '0 : fifo_dout;
    assign bus.tx_last    = !fifo_empty && is_last;
    assign bus.tx_be      = fifo_empty ? 4'b0000 : (is_last ? last_be(pkt_q[1:0]) : 4'b1111);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.err_arm    = err_q;

endmodule

// File: tb/tb_usb3_ep0_tx.sv
// Directed bench for usb3_ep0_tx: three instances (RD_LAT=1,2,3) share one stimulus,
// each with its own latency-matched buffer model and output monitor.
`timescale 1ns/1ps
module tb_usb3_ep0_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hasdata = 1'b0, req = 1'b0, abort = 1'b0, ready = 1'b1, ack_en = 1'b1;
    logic        clr = 1'b1, rnd = 1'b0;
    logic [10:0] len = '0;
    int          cyc = 0;
    int          nchk = 0, nerr = 0;

    logic [31:0] mem [512];
    int          nst [3], nw [3], nl [3], nar [3], ahi [3], stc [3], arc [3];
    logic [3:0]  lbe [3];
    logic [10:0] slen [3][8];
    logic [31:0] wq [3][512];
    logic [2:0]  busy_v, arm_v, err_v, vld_v;
    logic [8:0]  addr_v [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] expw(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        usb3_ep0_tx_if bus ();
        logic [31:0] pipe [3];
        logic        arm_d = 1'b0;

        usb3_ep0_tx #(.MAX_PKT(512), .RD_LAT(g + 1), .ARM_TIMEOUT(255)) u_dut (
            .local_clk (clk),
            .reset_n   (rst_n),
            .bus       (bus)
        );

        assign bus.ep_hasdata = hasdata;
        assign bus.ep_len     = len;
        assign bus.tx_req     = req;
        assign bus.tx_abort   = abort;
        assign bus.tx_ready   = ready;
        assign bus.ep_rd_q    = pipe[g];
        assign bus.ep_arm_ack = ack_en & arm_d;
        assign busy_v[g]      = bus.busy;
        assign arm_v[g]       = bus.ep_arm;
        assign err_v[g]       = bus.err_arm;
        assign vld_v[g]       = bus.tx_valid;
        assign addr_v[g]      = bus.ep_rd_addr;

        always @(posedge clk) begin
            pipe[0] <= mem[bus.ep_rd_addr];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            arm_d   <= bus.ep_arm;
        end

        always @(negedge clk) begin
            if (clr) begin
                nst[g] <= 0; nw[g] <= 0; nl[g] <= 0; nar[g] <= 0; ahi[g] <= 0;
            end else begin
                if (bus.tx_start) begin
                    if (nst[g] < 8) slen[g][nst[g]] <= bus.tx_len;
                    nst[g] <= nst[g] + 1;
                    stc[g] <= cyc;
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (nw[g] < 512) wq[g][nw[g]] <= bus.tx_data;
                    nw[g] <= nw[g] + 1;
                    if (bus.tx_last) begin
                        nl[g]  <= nl[g] + 1;
                        lbe[g] <= bus.tx_be;
                    end
                end
                if (bus.ep_arm) begin
                    ahi[g] <= ahi[g] + 1;
                    if (!arm_d) begin
                        nar[g] <= nar[g] + 1;
                        arc[g] <= cyc;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        req = 1'b1; tick(); req = 1'b0;
    endtask

    task automatic start_xfer(input logic [10:0] l);
        clr = 1'b1; tick(); clr = 1'b0;
        len = l; hasdata = 1'b1; tick(); tick();
        pulse_req();
    endtask

    task automatic wait_lasts(input int n, input string tag);
        int t = 0;
        while (!(nl[0] >= n && nl[1] >= n && nl[2] >= n) && t < 3000) begin
            if (rnd) ready = 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        ready = 1'b1;
        chk({tag, " done"}, 32'(t < 3000), 32'd1);
    endtask

    task automatic wait_arm(input string tag);
        int t = 0;
        while (!(nar[0] >= 1 && nar[1] >= 1 && nar[2] >= 1) && t < 400) begin
            tick();
            t++;
        end
        chk({tag, " arm"}, 32'(t < 400), 32'd1);
    endtask

    task automatic release_ep(input string tag);
        repeat (4) tick();
        hasdata = 1'b0;
        repeat (3) tick();
        for (int g = 0; g < 3; g++) chk($sformatf("%s idle%0d", tag, g), 32'(busy_v[g]), 32'd0);
    endtask

    task automatic chk_words(input string tag, input int n);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s nw%0d", tag, g), 32'(nw[g]), 32'(n));
            for (int k = 0; k < n; k++)
                chk($sformatf("%s w%0d.%0d", tag, g, k), wq[g][k], expw(k));
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = expw(i);
        repeat (3) tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst busy%0d", g), 32'(busy_v[g]), 32'd0);
            chk($sformatf("rst vld%0d", g), 32'(vld_v[g]), 32'd0);
            chk($sformatf("rst arm%0d", g), 32'(arm_v[g]), 32'd0);
            chk($sformatf("rst err%0d", g), 32'(err_v[g]), 32'd0);
            chk($sformatf("rst addr%0d", g), 32'(addr_v[g]), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // 18 bytes; ep_len change after latching must not matter
        clr = 1'b1; tick(); clr = 1'b0;
        len = 11'd18; hasdata = 1'b1; tick();
        len = 11'd99; tick();
        pulse_req();
        wait_lasts(1, "t1");
        chk_words("t1", 5);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("t1 len%0d", g), 32'(slen[g][0]), 32'd18);
            chk($sformatf("t1 be%0d", g), 32'(lbe[g]), 32'hC);
            chk($sformatf("t1 addr%0d", g), 32'(addr_v[g]), 32'd5);
        end
        wait_arm("t1");
        repeat (4) tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("t1 armhi%0d", g), 32'(ahi[g]), 32'd2);
            chk($sformatf("t1 rel busy%0d", g), 32'(busy_v[g]), 32'd1);
        end
        release_ep("t1");

        // status ZLP
        start_xfer(11'd0);
        wait_arm("t2");
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("t2 starts%0d", g), 32'(nst[g]), 32'd1);
            chk($sformatf("t2 len%0d", g), 32'(slen[g][0]), 32'd0);
            chk($sformatf("t2 armlat%0d", g), 32'(arc[g] - stc[g]), 32'd1);
        end
        chk_words("t2", 0);
        release_ep("t2");

        // 1030 bytes: 512 + 512 + 6
        start_xfer(11'd1030);
        wait_lasts(1, "t3a");
        tick(); tick(); pulse_req();
        wait_lasts(2, "t3b");
        tick(); tick();
        for (int g = 0; g < 3; g++) chk($sformatf("t3 early arm%0d", g), 32'(nar[g]), 32'd0);
        pulse_req();
        wait_lasts(3, "t3c");
        wait_arm("t3");
        chk_words("t3", 258);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("t3 len0.%0d", g), 32'(slen[g][0]), 32'd512);
            chk($sformatf("t3 len1.%0d", g), 32'(slen[g][1]), 32'd512);
            chk($sformatf("t3 len2.%0d", g), 32'(slen[g][2]), 32'd6);
            chk($sformatf("t3 be%0d", g), 32'(lbe[g]), 32'hC);
            chk($sformatf("t3 addr%0d", g), 32'(addr_v[g]), 32'd258);
            chk($sformatf("t3 starts%0d", g), 32'(nst[g]), 32'd3);
        end
        release_ep("t3");

        // 64 bytes with random backpressure
        rnd = 1'b1;
        start_xfer(11'd64);
        wait_lasts(1, "t4");
        rnd = 1'b0;
        chk_words("t4", 16);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("t4 len%0d", g), 32'(slen[g][0]), 32'd64);
            chk($sformatf("t4 be%0d", g), 32'(lbe[g]), 32'hF);
        end
        wait_arm("t4");
        release_ep("t4");

        // abort mid-DATA of a stalled 40-byte response, then resend
        ready = 1'b0;
        start_xfer(11'd40);
        repeat (10) tick();
        for (int g = 0; g < 3; g++) chk($sformatf("t5 stall vld%0d", g), 32'(vld_v[g]), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("t5 abort idle%0d", g), 32'(busy_v[g]), 32'd0);
            chk($sformatf("t5 abort vld%0d", g), 32'(vld_v[g]), 32'd0);
        end
        ready = 1'b1;
        repeat (5) tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("t5 no arm%0d", g), 32'(nar[g]), 32'd0);
            chk($sformatf("t5 no words%0d", g), 32'(nw[g]), 32'd0);
        end
        start_xfer(11'd40);
        wait_lasts(1, "t5");
        chk_words("t5", 10);
        for (int g = 0; g < 3; g++) chk($sformatf("t5 len%0d", g), 32'(slen[g][0]), 32'd40);
        wait_arm("t5");
        release_ep("t5");

        // arm ack never comes
        ack_en = 1'b0;
        start_xfer(11'd4);
        wait_arm("t6");
        repeat (300) tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("t6 armhi%0d", g), 32'(ahi[g]), 32'd255);
            chk($sformatf("t6 err%0d", g), 32'(err_v[g]), 32'd1);
            chk($sformatf("t6 armlow%0d", g), 32'(arm_v[g]), 32'd0);
        end
        ack_en = 1'b1;
        release_ep("t6");
        for (int g = 0; g < 3; g++) chk($sformatf("t6 sticky%0d", g), 32'(err_v[g]), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
